// File: rtl/xor_frame_accumulator.sv
// Accumulates (xor, xnor) decode beats over a frame and presents one summary
// per frame: parity, ones count, length, complement-error and overflow flags.
module xor_frame_accumulator #(
    parameter int CNT_W   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             xor_i,
    input  logic             xnor_i,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_ones,
    output logic [CNT_W-1:0] out_len,
    output logic             out_err,
    output logic             out_ovf,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The source holds its payload stable while valid is high and not ready;
    // ready never depends on valid on the same side.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             par_q, par_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             at_max;
    logic [CNT_W-1:0] len_inc;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign len_inc   = len_q + CNT_W'(1);
    assign at_max    = (len_inc == CNT_W'(MAX_LEN));

    always_comb begin
        state_next = state;
        par_d      = par_q;
        ones_d     = ones_q;
        len_d      = len_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    par_d  = par_q ^ xor_i;
                    ones_d = ones_q + CNT_W'(xor_i);
                    len_d  = len_inc;
                    err_d  = err_q | (xor_i == xnor_i);
                    // Overflow only when the length limit, not in_last, closed the frame.
                    ovf_d  = at_max & ~in_last;
                    if (in_last || at_max) begin
                        state_next = HOLD;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                    par_d      = 1'b0;
                    ones_d     = '0;
                    len_d      = '0;
                    err_d      = 1'b0;
                    ovf_d      = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            par_q  <= 1'b0;
            ones_q <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_next;
            par_q  <= par_d;
            ones_q <= ones_d;
            len_q  <= len_d;
            err_q  <= err_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_parity = par_q;
    assign out_ones   = ones_q;
    assign out_len    = len_q;
    assign out_err    = err_q;
    assign out_ovf    = ovf_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_xor_frame_accumulator.sv
// Directed bench for xor_frame_accumulator: reset, normal, error, overflow,
// backpressure and sparse-input frames with hand-computed summaries.
module tb_xor_frame_accumulator;

    localparam int CNT_W   = 8;
    localparam int MAX_LEN = 16;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             xor_i;
    logic             xnor_i;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [CNT_W-1:0] out_ones;
    logic [CNT_W-1:0] out_len;
    logic             out_err;
    logic             out_ovf;
    logic [1:0]       state_dbg;

    int checks;
    int failures;

    xor_frame_accumulator #(.CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .xor_i      (xor_i),
        .xnor_i     (xnor_i),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_ones   (out_ones),
        .out_len    (out_len),
        .out_err    (out_err),
        .out_ovf    (out_ovf),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic x, input logic xn, input logic last);
        in_valid = 1'b1;
        xor_i    = x;
        xnor_i   = xn;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        xor_i    = 1'b0;
        xnor_i   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic summary(input string tag, input logic par, input int ones, input int len,
                           input logic err, input logic ovf);
        chk({tag, "_valid"},  out_valid, 1);
        chk({tag, "_parity"}, out_parity, par);
        chk({tag, "_ones"},   out_ones, ones);
        chk({tag, "_len"},    out_len, len);
        chk({tag, "_err"},    out_err, err);
        chk({tag, "_ovf"},    out_ovf, ovf);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, out_valid, 0);
        chk({tag, "_done_len"},   out_len, 0);
        chk({tag, "_done_ready"}, in_ready, 1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        xor_i     = 1'b0;
        xnor_i    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_len", out_len, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_state", state_dbg, S_IDLE);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a frame discards the partial frame.
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b1, 1'b1, 1'b0);
        send_beat(1'b1, 1'b0, 1'b0);
        chk("mid_state", state_dbg, S_ACCUM);
        chk("mid_len", out_len, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_state", state_dbg, S_IDLE);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_len", out_len, 0);
        chk("mrst_ones", out_ones, 0);
        chk("mrst_parity", out_parity, 0);
        chk("mrst_err", out_err, 0);
        send_beat(1'b0, 1'b1, 1'b0);
        send_beat(1'b1, 1'b0, 1'b1);
        summary("after_rst", 1'b1, 1, 2, 1'b0, 1'b0);
        consume("after_rst");
        tick();

        // Normal frame.
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b1, 1'b0);
        send_beat(1'b1, 1'b0, 1'b0);
        chk("norm_pre_valid", out_valid, 0);
        send_beat(1'b1, 1'b0, 1'b1);
        summary("norm", 1'b1, 3, 4, 1'b0, 1'b0);
        chk("norm_state", state_dbg, S_HOLD);

        // Backpressure with a single-beat frame waiting upstream.
        in_valid = 1'b1;
        xor_i    = 1'b1;
        xnor_i   = 1'b0;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_len", out_len, 4);
            chk("bp_ones", out_ones, 3);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_hs_valid", out_valid, 0);
        chk("bp_hs_state", state_dbg, S_IDLE);
        chk("bp_hs_len", out_len, 0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        summary("single", 1'b1, 1, 1, 1'b0, 1'b0);
        consume("single");

        // Complement error.
        send_beat(1'b0, 1'b1, 1'b0);
        send_beat(1'b1, 1'b1, 1'b0);
        send_beat(1'b0, 1'b1, 1'b1);
        summary("err", 1'b1, 1, 3, 1'b1, 1'b0);
        consume("err");

        // Overflow: frame closed by the length limit.
        for (int i = 0; i < MAX_LEN - 1; i++) send_beat(1'b1, 1'b0, 1'b0);
        chk("ovf_pre_valid", out_valid, 0);
        chk("ovf_pre_state", state_dbg, S_ACCUM);
        send_beat(1'b1, 1'b0, 1'b0);
        summary("ovf", 1'b0, 16, 16, 1'b0, 1'b1);
        consume("ovf");

        // in_last coinciding with the limit is not an overflow.
        for (int i = 0; i < MAX_LEN - 1; i++) send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b1, 1'b0, 1'b1);
        summary("ovf_last", 1'b0, 16, 16, 1'b0, 1'b0);
        consume("ovf_last");

        // Sparse input: idle cycles between beats change nothing.
        send_beat(1'b1, 1'b0, 1'b0);
        xor_i   = 1'b1;
        xnor_i  = 1'b1;
        in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sparse_len", out_len, 1);
            chk("sparse_state", state_dbg, S_ACCUM);
        end
        send_beat(1'b0, 1'b1, 1'b1);
        summary("sparse", 1'b1, 1, 2, 1'b0, 1'b0);
        consume("sparse");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_frame_accumulator.md
Name: xor_frame_accumulator

Overview:
- Downstream consumer of the xor/xnor decode stage.
- Takes one (xor, xnor) pair per accepted beat and accumulates it over a frame delimited by a last flag.
- Checks that the two decode outputs are always complementary.
- Emits one per-frame summary (parity, ones count, length, error flags) over a valid/ready handshake.

Parameters:
- CNT_W, 8, width of the ones and length counters.
- MAX_LEN, 16, maximum beats per frame; 1 ≤ MAX_LEN ≤ 2^CNT_W−1. The frame is force-closed when this is reached.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- xor_i  input  1  xor output of the decode stage.
- xnor_i  input  1  xnor output of the decode stage.
- in_last  input  1  marks the final beat of a frame.
- out_valid  output  1  frame summary valid.
- out_ready  input  1  downstream accepts the summary.
- out_parity  output  1  XOR of all xor_i in the frame.
- out_ones  output  CNT_W  count of beats with xor_i=1.
- out_len  output  CNT_W  beats in the frame.
- out_err  output  1  at least one beat had xor_i==xnor_i.
- out_ovf  output  1  frame closed by MAX_LEN rather than in_last.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; all accumulators clear.
  - out_valid=0, out_parity=0, out_ones=0, out_len=0, out_err=0, out_ovf=0.
  - Reset wins over every other event, including mid-frame and during HOLD; a partial frame is discarded with no output.
- States:
  - IDLE: no beats accepted yet in the current frame.
  - ACCUM: at least one beat accepted, frame still open.
  - HOLD: summary presented.
- in_ready:
  - in_ready=1 in IDLE and ACCUM; in_ready=0 in HOLD.
  - in_ready is a registered state decode and does not depend on in_valid.
- Accept: a beat is accepted when in_valid & in_ready at a clk edge. For each accepted beat:
  - par ^= xor_i
  - ones += xor_i
  - len += 1
  - err |= (xor_i == xnor_i)
- Transitions:
  - IDLE → ACCUM on an accepted beat with in_last=0 and new len < MAX_LEN.
  - IDLE/ACCUM → HOLD on an accepted beat with in_last=1, or when new len == MAX_LEN.
  - ACCUM → ACCUM on any other accepted beat; idle cycles (in_valid=0) leave all state unchanged.
  - HOLD → IDLE on out_valid & out_ready.
- Output timing and values:
  - The closing beat's contribution is included in the summary.
  - out_valid=1 in the cycle after the closing beat is accepted, i.e. 1-cycle latency.
  - out_ovf=1 only if the frame closed on len==MAX_LEN with in_last=0. If in_last=1 coincides with len==MAX_LEN, out_ovf=0.
  - Summary outputs are registered and stable throughout HOLD; out_valid stays high until the handshake completes.
- Handshake completion:
  - On out_valid & out_ready: accumulators clear, out_valid drops next cycle, state returns to IDLE.
  - No new beat is accepted in that same cycle because in_ready=0. The minimum gap between frames is 1 idle cycle after the summary is consumed.
- Widths and ranges:
  - Counters are unsigned CNT_W.
  - len never exceeds MAX_LEN, so no wrap is possible.
  - ones ≤ len.
- Single-beat frame: a beat with in_last=1 accepted in IDLE goes straight to HOLD with out_len=1.
- Unused inputs: xor_i, xnor_i and in_last are ignored when the beat is not accepted.

Test Plan:
- Reset mid-ACCUM: 3 beats accepted, then rst_n=0 for 1 cycle → all outputs 0, state IDLE, in_ready=1; a following frame summary excludes the 3 beats.
- Normal frame: (xor,xnor) beats (1,0),(0,1),(1,0),(1,0) with last on the 4th → next cycle out_valid=1, out_parity=1, out_ones=3, out_len=4, out_err=0, out_ovf=0.
- Complement error: frame (0,1),(1,1),(0,1) with last on the 3rd → out_err=1, out_ones=1, out_len=3, out_parity=1.
- Overflow: MAX_LEN=16, 16 beats of (1,0) with in_last=0 throughout → summary after the 16th beat: out_len=16, out_ones=16, out_parity=0, out_ovf=1. Repeat with in_last=1 on beat 16 → out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after a summary, with in_valid=1 → in_ready=0 and outputs stable for 5 cycles. Then out_ready=1 → out_valid=0 next cycle, and the first beat of the next frame is accepted 1 cycle after the handshake.
- Sparse input: a 2-beat frame with 3 in_valid=0 cycles between beats → result identical to the back-to-back case (out_len=2), with no spurious accepts.
